// File: rtl/px_scan.sv
`default_nettype none
// ============================================================================
// Module   : px_scan
// Brief    : Raster pixel sequencer feeding N_BALLS metaball instances;
//            sums their field outputs with saturation and thresholds each pixel.
// Revision : 1.0 - initial release
// ============================================================================
module px_scan #(
    parameter int          H_RES    = 64,
    parameter int          V_RES    = 48,
    parameter int          N_BALLS  = 3,
    parameter logic [31:0] X_ORIGIN = 32'h0000_0000,
    parameter logic [31:0] Y_ORIGIN = 32'h0000_0000,
    parameter logic [31:0] X_STEP   = 32'h0000_8000,
    parameter logic [31:0] Y_STEP   = 32'h0000_8000,
    parameter logic [31:0] THRESH   = 32'h0000_8000,
    localparam int         c_COL_W  = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int         c_ROW_W  = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   px_stb,
    output logic [31:0]            p_x,
    output logic [31:0]            p_y,
    input  logic [N_BALLS-1:0]     ball_vld,
    input  logic [32*N_BALLS-1:0]  ball_out,
    output logic                   mov_en,
    output logic                   pix_vld,
    input  logic                   pix_rdy,
    output logic [c_COL_W-1:0]     pix_col,
    output logic [c_ROW_W-1:0]     pix_row,
    output logic [31:0]            pix_sum,
    output logic                   pix_on,
    output logic                   frame_done
);

    localparam int         c_IDX_W   = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_STB   = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_ACC   = 3'd3;
    localparam logic [2:0] c_S_EMIT  = 3'd4;
    localparam logic [2:0] c_S_FRAME = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [31:0]         r_px;
    logic [31:0]         r_py;
    logic [31:0]         r_acc;
    logic                r_pix_on;
    logic [N_BALLS-1:0]  r_seen_low;
    logic [N_BALLS-1:0]  r_done;
    logic [N_BALLS-1:0]  w_done_nxt;
    logic [31:0]         r_cap [N_BALLS];
    logic [31:0]         w_ball_out [N_BALLS];
    logic [c_IDX_W-1:0]  r_idx;
    logic [31:0]         w_cap_sel;
    logic [31:0]         w_acc_nxt;
    logic                w_acc_last;
    logic                w_last_col;
    logic                w_last_row;

    generate
        for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_unpack
            assign w_ball_out[gi] = ball_out[32*gi +: 32];
        end
    endgenerate

    function automatic logic [31:0] f_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    // A ball completes only on a rising vld seen after a low sample, so stale highs are ignored
    assign w_done_nxt = r_done | (r_seen_low & ball_vld);
    assign w_acc_last = (r_idx == c_IDX_W'(N_BALLS - 1));
    assign w_last_col = (r_col == c_COL_W'(H_RES - 1));
    assign w_last_row = (r_row == c_ROW_W'(V_RES - 1));
    assign w_acc_nxt  = f_sat_add(r_acc, w_cap_sel);

    always_comb begin
        w_cap_sel = r_cap[0];
        for (int i = 1; i < N_BALLS; i++) begin
            if (r_idx == c_IDX_W'(i))
                w_cap_sel = r_cap[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        px_stb      = 1'b0;
        pix_vld     = 1'b0;
        mov_en      = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            c_S_IDLE:  if (en) w_state_nxt = c_S_STB;
            c_S_STB: begin
                px_stb      = 1'b1;
                w_state_nxt = c_S_WAIT;
            end
            c_S_WAIT:  if (&w_done_nxt) w_state_nxt = c_S_ACC;
            c_S_ACC:   if (w_acc_last) w_state_nxt = c_S_EMIT;
            c_S_EMIT: begin
                pix_vld = 1'b1;
                if (pix_rdy)
                    w_state_nxt = (w_last_col && w_last_row) ? c_S_FRAME : c_S_STB;
            end
            c_S_FRAME: begin
                mov_en      = 1'b1;
                frame_done  = 1'b1;
                w_state_nxt = en ? c_S_STB : c_S_IDLE;
            end
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_px       <= X_ORIGIN;
            r_py       <= Y_ORIGIN;
            r_acc      <= '0;
            r_pix_on   <= 1'b0;
            r_seen_low <= '0;
            r_done     <= '0;
            r_idx      <= '0;
            for (int i = 0; i < N_BALLS; i++)
                r_cap[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_S_STB: begin
                    r_seen_low <= '0;
                    r_done     <= '0;
                    r_acc      <= '0;
                    r_pix_on   <= 1'b0;
                    r_idx      <= '0;
                end
                c_S_WAIT: begin
                    r_seen_low <= r_seen_low | ~ball_vld;
                    r_done     <= w_done_nxt;
                    for (int i = 0; i < N_BALLS; i++) begin
                        if (!r_done[i] && r_seen_low[i] && ball_vld[i])
                            r_cap[i] <= w_ball_out[i];
                    end
                end
                c_S_ACC: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + c_IDX_W'(1);
                    if (w_acc_last)
                        r_pix_on <= ($signed(w_acc_nxt) >= $signed(THRESH));
                end
                c_S_EMIT: begin
                    // Coordinates advance only on transfer so they stay stable while stalled
                    if (pix_rdy) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            r_px  <= X_ORIGIN;
                            if (w_last_row) begin
                                r_row <= '0;
                                r_py  <= Y_ORIGIN;
                            end else begin
                                r_row <= r_row + c_ROW_W'(1);
                                r_py  <= r_py + Y_STEP;
                            end
                        end else begin
                            r_col <= r_col + c_COL_W'(1);
                            r_px  <= r_px + X_STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign p_x     = r_px;
    assign p_y     = r_py;
    assign pix_col = r_col;
    assign pix_row = r_row;
    assign pix_sum = r_acc;
    assign pix_on  = r_pix_on;

endmodule
`default_nettype wire
